alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Issuing side of the ALU operand/control interface. Drives a, b and ctrl into the external 8-bit ALU and consumes its result.
- Accepts one 3-address register instruction per handshake and reads both operands from an internal register file.
- Sequences the operands to the ALU, captures the result and writes it back to the register file.
- Sits between instruction decode and the ALU in the assignment datapath. Also exposes a load port and a debug read port.

Parameters:
- DATA_W, 8, operand/result width; must match ALU a/b/result width.
- REG_AW, 2, register-address width; register file has 2**REG_AW entries.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  2+3*REG_AW  fields are {op[1:0], rd, rs1, rs2}, MSB first.
- ld_en  in  1  register-file direct load strobe.
- ld_addr  in  REG_AW  load address.
- ld_data  in  DATA_W  load data.
- alu_a  out  DATA_W  ALU operand a (registered).
- alu_b  out  DATA_W  ALU operand b (registered).
- alu_ctrl  out  2  ALU control (registered); op field passed through unmodified.
- alu_result  in  DATA_W  ALU combinational result.
- done  out  1  one-cycle pulse on writeback.
- wb_data  out  DATA_W  value written back; valid while done=1, held afterwards.
- op_count  out  CNT_W  number of completed writebacks.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational register-file read of dbg_addr.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers and the register file clear to 0; state = IDLE.
  - alu_a, alu_b, alu_ctrl, wb_data, op_count and done are 0.
- in_ready = (state==IDLE). It is combinational from state, so it reads 1 during reset.
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: on in_valid&&in_ready, latch in_instr, go to READ. Otherwise stay in IDLE.
  - READ: alu_a<=rf[rs1], alu_b<=rf[rs2], alu_ctrl<=op. Go to EXEC.
  - EXEC: ALU inputs are stable for this cycle; res_q<=alu_result at the end of EXEC. Go to WRITE.
  - WRITE: rf[rd]<=res_q, wb_data<=res_q, op_count<=op_count+1 (wraps modulo 2**CNT_W). Go to IDLE.
- done is registered and is high for exactly the cycle after the WRITE edge, which is the first IDLE cycle.
- Latency: handshake edge at cycle N; done high at cycle N+4; next instruction can be accepted in the same cycle that done is high.
- alu_a, alu_b and alu_ctrl hold their last values outside READ. The bench samples alu_result only in EXEC.
- Load port:
  - ld_en is honoured only in IDLE; while busy it is ignored and no write occurs.
  - ld_en together with an accepted instruction in the same IDLE cycle: the load is written that edge. READ then sees the loaded value.
- Hazards:
  - rd equal to rs1 or rs2 is legal; operands are read in READ, before writeback.
  - Back-to-back instructions see the previous writeback, because WRITE completes before the next READ.
- Reset asserted mid-operation aborts immediately: no writeback, op_count unchanged from reset value 0, state IDLE.
- in_instr changing after acceptance has no effect; the instruction is latched.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> in_ready=1, done=0, op_count=0, dbg_data=0 for all four addresses.
- Single op:
  - Stimulus: load r1=0x24, r2=0x04; issue op=01 rd=3 rs1=1 rs2=2; stub drives alu_result=0x20 in EXEC.
  - Response: at READ edge alu_a=0x24, alu_b=0x04, alu_ctrl=01; done pulses at accept+4; wb_data=0x20; r3=0x20; op_count=1.
- Back-to-back dependency:
  - Stimulus: issue op=11 rd=0 rs1=3 rs2=3 on the cycle done is high after the single-op test (r3=0x20).
  - Response: accepted that cycle; alu_a=alu_b=0x20; alu_ctrl=11.
- Busy protection: assert in_valid and ld_en (addr 1, data 0xFF) during READ/EXEC/WRITE -> in_ready=0, no second accept, r1 unchanged (0x24).
- Reset mid-op: assert rst_n=0 during EXEC -> no done pulse, rf all 0, state IDLE, in_ready=1 after release.
- Counter wrap: complete 256 ops -> op_count returns to 0x00 and done pulses 256 times.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issuing side of the ALU interface: reads two operands from a local register file,
// presents them to an external combinational ALU and writes the result back.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2+3*REG_AW-1:0]    in_instr,
  input  logic                     ld_en,
  input  logic [REG_AW-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [1:0]               alu_ctrl,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     done,
  output logic [DATA_W-1:0]        wb_data,
  output logic [CNT_W-1:0]         op_count,
  input  logic [REG_AW-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned INSTR_W = 2 + 3 * REG_AW;
  localparam int unsigned NREG    = 1 << REG_AW;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t              state, state_nxt;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   rf [NREG];

  logic [1:0]          op_q;
  logic [REG_AW-1:0]   rd_q, rs1_q, rs2_q;

  // Field split of the latched instruction: {op, rd, rs1, rs2}
  assign op_q  = instr_q[INSTR_W-1 -: 2];
  assign rd_q  = instr_q[3*REG_AW-1 -: REG_AW];
  assign rs1_q = instr_q[2*REG_AW-1 -: REG_AW];
  assign rs2_q = instr_q[REG_AW-1:0];

  assign in_ready = (state == IDLE);
  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: instruction latch, operand issue, result capture and writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      res_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      done     <= 1'b0;
      wb_data  <= '0;
      op_count <= '0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      done <= (state == WRITE);
      case (state)
        IDLE: begin
          if (ld_en)    rf[ld_addr] <= ld_data;
          if (in_valid) instr_q     <= in_instr;
        end
        READ: begin
          alu_a    <= rf[rs1_q];
          alu_b    <= rf[rs2_q];
          alu_ctrl <= op_q;
        end
        EXEC: res_q <= alu_result;
        WRITE: begin
          rf[rd_q] <= res_q;
          wb_data  <= res_q;
          op_count <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: transaction-level model plus literal spot checks.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_instr = '0;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_ctrl;
  logic       done;
  logic [7:0] wb_data, op_count, dbg_data;
  logic [1:0] dbg_addr = '0;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .done(done), .wb_data(wb_data), .op_count(op_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU stub: 00 and, 01 sub, 10 xor, 11 add
  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a - b;
      2'b10:   return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_ctrl, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one instruction in flight, tracked by edges elapsed since acceptance
  logic [7:0] m_rf [4];
  logic [7:0] m_a, m_b, m_wb, m_cnt, m_res, m_ins;
  logic [1:0] m_ctrl;
  logic       m_busy, m_done;
  int         m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_rf[i] = '0;
      m_a = '0; m_b = '0; m_wb = '0; m_cnt = '0; m_res = '0; m_ins = '0;
      m_ctrl = '0; m_busy = 1'b0; m_done = 1'b0; m_edges = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_edges++;
        if (m_edges == 1) begin
          m_a    = m_rf[m_ins[3:2]];
          m_b    = m_rf[m_ins[1:0]];
          m_ctrl = m_ins[7:6];
          m_res  = alu_ref(m_ctrl, m_a, m_b);
        end
        if (m_edges == 3) begin
          m_rf[m_ins[5:4]] = m_res;
          m_wb   = m_res;
          m_cnt  = m_cnt + 8'd1;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else begin
        if (ld_en) m_rf[ld_addr] = ld_data;
        if (in_valid) begin
          m_busy  = 1'b1;
          m_edges = 0;
          m_ins   = in_instr;
        end
      end
    end
  end

  // Per-cycle comparison, mid-way between the driving negedge and the next posedge
  always @(negedge clk) begin
    #2;
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("done",     32'(done),     32'(m_done));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("wb_data",  32'(wb_data),  32'(m_wb));
    chk("alu_a",    32'(alu_a),    32'(m_a));
    chk("alu_b",    32'(alu_b),    32'(m_b));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
    chk("dbg_data", 32'(dbg_data), 32'(m_rf[dbg_addr]));
    if (done) done_seen++;
  end

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_rf_zero();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk("rf_zero", 32'(dbg_data), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("ready_in_reset", 32'(in_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_done",  32'(done),     32'h0);
    chk("rst_count", 32'(op_count), 32'h0);
    check_rf_zero();

    // Single op: r3 = r1 - r2 = 0x24 - 0x04
    load(2'd1, 8'h24);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h04;
    @(negedge clk);
    ld_en = 1'b0;
    in_valid = 1'b1; in_instr = {2'b01, 2'd3, 2'd1, 2'd2};
    @(negedge clk);
    in_valid = 1'b0; in_instr = 8'hFF;
    @(negedge clk);
    #3;
    chk("single_a",    32'(alu_a),    32'h24);
    chk("single_b",    32'(alu_b),    32'h04);
    chk("single_ctrl", 32'(alu_ctrl), 32'h1);
    @(negedge clk);
    #3;
    chk("single_no_done", 32'(done), 32'h0);
    @(negedge clk);
    // Done cycle: check writeback and issue the dependent op r0 = r3 + r3 in the same cycle
    in_valid = 1'b1; in_instr = {2'b11, 2'd0, 2'd3, 2'd3}; dbg_addr = 2'd3;
    #3;
    chk("single_done",  32'(done),     32'h1);
    chk("single_wb",    32'(wb_data),  32'h20);
    chk("single_count", 32'(op_count), 32'h1);
    chk("single_r3",    32'(dbg_data), 32'h20);

    // Busy protection: keep requesting and loading r1=0xFF while the op runs
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hFF; in_instr = {2'b00, 2'd1, 2'd1, 2'd1};
    #3;
    chk("busy_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    #3;
    chk("b2b_a",    32'(alu_a),    32'h20);
    chk("b2b_b",    32'(alu_b),    32'h20);
    chk("b2b_ctrl", 32'(alu_ctrl), 32'h3);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0; ld_en = 1'b0; dbg_addr = 2'd1;
    #3;
    chk("b2b_done", 32'(done),     32'h1);
    chk("busy_r1",  32'(dbg_data), 32'h24);
    dbg_addr = 2'd0;
    #1;
    chk("b2b_r0",   32'(dbg_data), 32'h40);
    chk("b2b_count", 32'(op_count), 32'h2);
    repeat (2) @(negedge clk);
    #3;
    chk("no_second_accept", 32'(op_count), 32'h2);

    // Reset during EXEC aborts the op
    @(negedge clk);
    in_valid = 1'b1; in_instr = {2'b00, 2'd2, 2'd0, 2'd1};
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("abort_ready", 32'(in_ready), 32'h1);
    chk("abort_count", 32'(op_count), 32'h0);
    chk("abort_done",  32'(done),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    check_rf_zero();
    repeat (4) @(negedge clk);

    // Counter wrap: 256 back-to-back ops with varied opcodes and registers
    load(2'd1, 8'h03);
    load(2'd2, 8'h05);
    done_seen = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_instr = 8'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    #3;
    chk("wrap_count", 32'(op_count), 32'h0);
    chk("wrap_dones", 32'(done_seen), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
